// File: rtl/miner_job_if.sv
// Bundle between the miner job controller and its environment: job load stream, core fan-out,
// hit collection, result handshake and status outputs.
interface miner_job_if #(
  parameter int NUM_CORES = 4
);
  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                    cfg_valid;
  logic [31:0]             cfg_data;
  logic                    cfg_ready;
  logic                    abort;

  logic                    core_start;
  logic [255:0]            job_digest_init;
  logic [255:0]            job_digest;
  logic [31:0]             job_merkle;
  logic [31:0]             job_time;
  logic [31:0]             job_target;
  logic [32*NUM_CORES-1:0] core_nonce_base;

  logic [NUM_CORES-1:0]    core_valid;
  logic [32*NUM_CORES-1:0] core_nonce;

  logic                    res_valid;
  logic                    res_ready;
  logic [31:0]             res_nonce;
  logic [31:0]             res_time;
  logic [CORE_W-1:0]       res_core;

  logic                    busy;
  logic [7:0]              led;

  modport master (
    output cfg_valid, cfg_data, abort, core_valid, core_nonce, res_ready,
    input  cfg_ready, core_start, job_digest_init, job_digest, job_merkle, job_time,
           job_target, core_nonce_base, res_valid, res_nonce, res_time, res_core, busy, led
  );

  modport slave (
    input  cfg_valid, cfg_data, abort, core_valid, core_nonce, res_ready,
    output cfg_ready, core_start, job_digest_init, job_digest, job_merkle, job_time,
           job_target, core_nonce_base, res_valid, res_nonce, res_time, res_core, busy, led
  );
endinterface

// File: rtl/miner_job_controller.sv
// SHA-256d job front-end: 20-word job load, per-core nonce fan-out, bounded sweep, round-robin
// hit collection. Optional macro TIME_ROLL_EN: on sweep expiry bump job_time and restart cores.
module miner_job_controller #(
  parameter int NUM_CORES    = 4,
  parameter int SWEEP_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  miner_job_if.slave bus
);
  localparam int                 CORE_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int                 SWEEP_W    = $clog2(SWEEP_CYCLES);
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(SWEEP_CYCLES - 1);
  localparam logic [4:0]         LAST_WORD  = 5'd19;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_EXHAUSTED
  } state_t;

  state_t state, state_next;

  logic [4:0]              word_cnt;
  logic [2:0]              slot;
  logic [SWEEP_W-1:0]      sweep_cnt;
  logic [255:0]            digest_init;
  logic [255:0]            digest;
  logic [31:0]             merkle;
  logic [31:0]             job_time;
  logic [31:0]             target;
  logic [31:0]             nonce;
  logic                    core_start;
  logic [32*NUM_CORES-1:0] nonce_base;

  logic [NUM_CORES-1:0]    pending;
  logic [31:0]             hit_nonce [NUM_CORES];
  logic [31:0]             hit_time  [NUM_CORES];
  logic [CORE_W-1:0]       rr_ptr;
  logic                    res_valid;
  logic [31:0]             res_nonce;
  logic [31:0]             res_time;
  logic [CORE_W-1:0]       res_core;
  logic                    overflow;
  logic [3:0]              hit_cnt;

  logic                    cfg_ready;
  logic                    cfg_fire;
  logic                    job_start;
  logic                    sweep_end;
  logic                    roll;
  logic [NUM_CORES-1:0]    hit_in;
  logic [NUM_CORES-1:0]    granted;
  logic                    arb_en;
  logic                    grant_vld;
  logic                    grant_fire;
  logic [CORE_W-1:0]       grant_idx;
  logic [CORE_W-1:0]       rr_next;
  logic [CORE_W-1:0]       cidx;
  int                      cand;
  logic                    drop;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // abort outranks every other event, so it is folded into the qualifiers below
  assign cfg_ready = (state != S_RUN);
  assign cfg_fire  = bus.cfg_valid && cfg_ready && !bus.abort;
  assign job_start = cfg_fire && (word_cnt == LAST_WORD);
  assign sweep_end = (state == S_RUN) && (sweep_cnt == SWEEP_LAST) && !bus.abort;
  assign slot      = 3'd7 - word_cnt[2:0];

`ifdef TIME_ROLL_EN
  assign roll = sweep_end;
`else
  assign roll = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_EXHAUSTED: if (cfg_fire) state_next = S_LOAD;
        S_LOAD:              if (job_start) state_next = S_RUN;
        S_RUN:               if (sweep_end && !roll) state_next = S_EXHAUSTED;
        default:             state_next = S_IDLE;
      endcase
    end
  end

  // Job load, sweep counter and core start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt    <= '0;
      sweep_cnt   <= '0;
      digest_init <= '0;
      digest      <= '0;
      merkle      <= '0;
      job_time    <= '0;
      target      <= '0;
      nonce       <= '0;
      core_start  <= 1'b0;
    end else begin
      if (bus.abort)     word_cnt <= '0;
      else if (cfg_fire) word_cnt <= job_start ? 5'd0 : word_cnt + 5'd1;

      if (cfg_fire) begin
        if (word_cnt < 5'd8) begin
          digest_init[{slot, 5'b0} +: 32] <= bus.cfg_data;
        end else if (word_cnt < 5'd16) begin
          digest[{slot, 5'b0} +: 32] <= bus.cfg_data;
        end else begin
          case (word_cnt)
            5'd16:   merkle   <= bus.cfg_data;
            5'd17:   job_time <= bus.cfg_data;
            5'd18:   target   <= bus.cfg_data;
            default: nonce    <= bus.cfg_data;
          endcase
        end
      end

      if (roll) job_time <= job_time + 32'd1;

      core_start <= job_start || roll;

      if (bus.abort || job_start || sweep_end) sweep_cnt <= '0;
      else if (state == S_RUN)                 sweep_cnt <= sweep_cnt + SWEEP_W'(1);
    end
  end

  always_comb begin
    nonce_base = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      nonce_base[32*i +: 32] = nonce + 32'(i);
    end
  end

  // Round-robin search: scanning offsets downwards leaves the nearest pending core at/after rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cidx      = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      cidx = CORE_W'(cand);
      if (pending[cidx]) begin
        grant_vld = 1'b1;
        grant_idx = cidx;
      end
    end
  end

  assign arb_en     = !res_valid || bus.res_ready;
  assign grant_fire = arb_en && grant_vld;
  assign rr_next    = (grant_idx == CORE_W'(NUM_CORES - 1)) ? '0 : grant_idx + CORE_W'(1);
  assign hit_in     = (state == S_RUN) ? bus.core_valid : '0;

  always_comb begin
    granted = '0;
    if (grant_fire) granted[grant_idx] = 1'b1;
  end

  // A hit lands only in a free slot or one being granted this cycle; otherwise it is lost
  assign drop = |(hit_in & pending & ~granted);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (hit_in[i] && (!pending[i] || granted[i])) begin
        hit_nonce[i] <= bus.core_nonce[32*i +: 32];
        hit_time[i]  <= job_time;
      end
    end
  end

  // Result register and hit bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      rr_ptr    <= '0;
      res_valid <= 1'b0;
      res_nonce <= '0;
      res_time  <= '0;
      res_core  <= '0;
      overflow  <= 1'b0;
      hit_cnt   <= '0;
    end else begin
      pending <= hit_in | (pending & ~granted);

      if (grant_fire) begin
        res_valid <= 1'b1;
        res_nonce <= hit_nonce[grant_idx];
        res_time  <= hit_time[grant_idx];
        res_core  <= grant_idx;
        rr_ptr    <= rr_next;
      end else if (bus.res_ready) begin
        res_valid <= 1'b0;
      end

      if (job_start)       hit_cnt <= '0;
      else if (grant_fire) hit_cnt <= sat_inc4(hit_cnt);

      if (job_start) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  assign bus.cfg_ready       = cfg_ready;
  assign bus.core_start      = core_start;
  assign bus.job_digest_init = digest_init;
  assign bus.job_digest      = digest;
  assign bus.job_merkle      = merkle;
  assign bus.job_time        = job_time;
  assign bus.job_target      = target;
  assign bus.core_nonce_base = nonce_base;
  assign bus.res_valid       = res_valid;
  assign bus.res_nonce       = res_nonce;
  assign bus.res_time        = res_time;
  assign bus.res_core        = res_core;
  assign bus.busy            = (state == S_RUN);
  assign bus.led             = {1'b1, state == S_RUN, state == S_EXHAUSTED, overflow, hit_cnt};
endmodule
